data_mem_lsu: RTL and testbench

- Load/store data memory fed directly by the ALU: ALU `out` is the byte address, and register-file rs2 supplies the store data.
- Performs RISC-V RV32I byte, halfword and word stores on the clock edge.
- Returns sign- or zero-extended load data combinationally, as the single-cycle datapath requires.
- Detects misaligned or illegal accesses, suppresses them, and latches the first fault in sticky status registers for debug.

---
 rtl/data_mem_lsu_if.sv | 35 +++
 rtl/data_mem_lsu.sv | 138 +++++++++++++
 tb/tb_data_mem_lsu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_lsu_if
// Description : Load/store bus between the single-cycle datapath and the
//               data memory LSU.
//   Request : mem_read, mem_write, funct3, addr (ALU out), wdata (rs2)
//   Response: rdata (combinational), misaligned (combinational),
//             fault_sticky / fault_addr / store_count (registered status)
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_lsu_if #(
  parameter int AW = 32
);
  logic          mem_read;
  logic          mem_write;
  logic [2:0]    funct3;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          misaligned;
  logic          fault_sticky;
  logic [AW-1:0] fault_addr;
  logic [15:0]   store_count;

  modport master (
    output mem_read, mem_write, funct3, addr, wdata,
    input  rdata, misaligned, fault_sticky, fault_addr, store_count
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata,
    output rdata, misaligned, fault_sticky, fault_addr, store_count
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_lsu
// Description : RV32I data memory with byte/half/word stores on the clock
//               edge, combinational sign/zero-extended loads, access checking
//               and a sticky first-fault latch.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (status only, memory not cleared)
//   bus  : data_mem_lsu_if.slave - request in, load data and status out
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 32
) (
  input  wire            clk,
  input  wire            rst,
  data_mem_lsu_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             acc;
  logic             illegal;
  logic             bad;
  logic             do_store;
  logic [3:0]       be;
  logic [31:0]      wlanes;
  logic [31:0]      word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      rdata_c;

  logic             fault_sticky_r;
  logic [AW-1:0]    fault_addr_r;
  logic [15:0]      store_count_r;

  // Upper address bits are intentionally dropped: addresses wrap.
  assign idx = bus.addr[IDX_W+1:2];
  assign acc = bus.mem_read | bus.mem_write;

  // Unsigned load encodings have no store counterpart, so they are illegal
  // when combined with a write.
  assign illegal = (bus.funct3 == 3'b011) | (bus.funct3 == 3'b110) |
                   (bus.funct3 == 3'b111) |
                   (bus.mem_write & ((bus.funct3 == F3_BU) | (bus.funct3 == F3_HU)));

  assign bad = acc & (illegal |
               (((bus.funct3 == F3_H) | (bus.funct3 == F3_HU)) & bus.addr[0]) |
               ((bus.funct3 == F3_W) & (bus.addr[1:0] != 2'b00)));

  assign do_store = bus.mem_write & ~bad & ~rst;

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    be     = 4'b0000;
    wlanes = bus.wdata;
    case (bus.funct3)
      F3_B: begin
        be     = 4'b0001 << bus.addr[1:0];
        wlanes = {4{bus.wdata[7:0]}};
      end
      F3_H: begin
        be     = bus.addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{bus.wdata[15:0]}};
      end
      F3_W: begin
        be     = 4'b1111;
        wlanes = bus.wdata;
      end
      default: begin
        be     = 4'b0000;
        wlanes = bus.wdata;
      end
    endcase
  end

  // Storage is never reset; only enabled lanes are updated.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // Read path sees pre-edge contents, giving read-before-write semantics.
  always_comb begin
    word    = mem[idx];
    byte_v  = word[{bus.addr[1:0], 3'b000} +: 8];
    half_v  = word[{bus.addr[1], 4'b0000} +: 16];
    rdata_c = 32'd0;
    if (bus.mem_read && !bad) begin
      case (bus.funct3)
        F3_B:    rdata_c = {{24{byte_v[7]}}, byte_v};
        F3_BU:   rdata_c = {24'd0, byte_v};
        F3_H:    rdata_c = {{16{half_v[15]}}, half_v};
        F3_HU:   rdata_c = {16'd0, half_v};
        F3_W:    rdata_c = word;
        default: rdata_c = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_sticky_r <= 1'b0;
      fault_addr_r   <= '0;
      store_count_r  <= 16'd0;
    end else begin
      if (do_store && (store_count_r != 16'hFFFF)) begin
        store_count_r <= store_count_r + 16'd1;
      end
      // Only the first fault after reset is captured.
      if (bad && !fault_sticky_r) begin
        fault_sticky_r <= 1'b1;
        fault_addr_r   <= bus.addr;
      end
    end
  end

  assign bus.rdata        = rdata_c;
  assign bus.misaligned   = bad;
  assign bus.fault_sticky = fault_sticky_r;
  assign bus.fault_addr   = fault_addr_r;
  assign bus.store_count  = store_count_r;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_lsu
// Description : Self-checking bench for data_mem_lsu. A vector table drives
//               load/store requests; expected combinational results are
//               queued when driven and popped when sampled. A small status
//               model tracks store_count and the first-fault latch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_lsu;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_lsu_if #(.AW(32)) bus ();

  data_mem_lsu #(.DEPTH_WORDS(256), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [15:0] m_count;
  logic        m_sticky;
  logic [31:0] m_faddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.funct3    = f3;
    bus.addr      = addr;
    bus.wdata     = wdata;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".sticky"}, {31'd0, bus.fault_sticky}, {31'd0, m_sticky});
    chk({tag, ".faddr"},  bus.fault_addr,             m_faddr);
    chk({tag, ".count"},  {16'd0, bus.store_count},   {16'd0, m_count});
  endtask

  // Drive one vector, compare combinational outputs, let the edge happen,
  // update the status model and compare registered outputs.
  task automatic apply(input vec_t v, input int n);
    exp_t e;
    exp_t got;
    string tag;
    tag = $sformatf("vec%0d", n);
    @(negedge clk);
    drive(v.rd, v.wr, v.f3, v.addr, v.wdata);
    e.rdata = v.exp_rdata;
    e.mis   = v.exp_mis;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    chk({tag, ".rdata"}, bus.rdata, got.rdata);
    chk({tag, ".mis"}, {31'd0, bus.misaligned}, {31'd0, got.mis});
    @(posedge clk);
    #1;
    if (v.wr && !v.exp_mis && m_count != 16'hFFFF) m_count = m_count + 16'd1;
    if (v.exp_mis && !m_sticky) begin
      m_sticky = 1'b1;
      m_faddr  = v.addr;
    end
    check_status(tag);
  endtask

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  vec_t vecs[$];

  initial begin
    //            rd    wr    f3      addr          wdata         exp_rdata     mis
    vecs.push_back('{1'b0, 1'b1, W,      32'h104,      32'h11112222, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b1, W,      32'h104,      32'h0B69EA82, 32'h11112222, 1'b0});
    vecs.push_back('{1'b1, 1'b0, W,      32'h104,      32'h0,        32'h0B69EA82, 1'b0});
    vecs.push_back('{1'b1, 1'b0, B,      32'h104,      32'h0,        32'hFFFFFF82, 1'b0});
    vecs.push_back('{1'b1, 1'b0, BU,     32'h104,      32'h0,        32'h00000082, 1'b0});
    vecs.push_back('{1'b1, 1'b0, H,      32'h106,      32'h0,        32'h00000B69, 1'b0});
    vecs.push_back('{1'b1, 1'b0, HU,     32'h104,      32'h0,        32'h0000EA82, 1'b0});
    vecs.push_back('{1'b1, 1'b0, H,      32'h104,      32'h0,        32'hFFFFEA82, 1'b0});
    vecs.push_back('{1'b1, 1'b0, B,      32'h107,      32'h0,        32'h0000000B, 1'b0});
    vecs.push_back('{1'b1, 1'b0, B,      32'h105,      32'h0,        32'hFFFFFFEA, 1'b0});
    vecs.push_back('{1'b1, 1'b0, BU,     32'h106,      32'h0,        32'h00000069, 1'b0});
    vecs.push_back('{1'b0, 1'b1, W,      32'h200,      32'hFFFFFFFF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, B,      32'h201,      32'hABCD1200, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, H,      32'h202,      32'h56781234, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, W,      32'h200,      32'h0,        32'h123400FF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, W,      32'h280,      32'h01020304, 32'h0,        1'b0});
    // Misaligned word store; its word index aliases 0x280.
    vecs.push_back('{1'b0, 1'b1, W,      32'h0B69EA82, 32'hDEADBEEF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, W,      32'h280,      32'h0,        32'h01020304, 1'b0});
    vecs.push_back('{1'b1, 1'b0, H,      32'h3,        32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'b111, 32'h104,      32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h104,      32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'b110, 32'h104,      32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b1, BU,     32'h104,      32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b1, HU,     32'h104,      32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, HU,     32'h105,      32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, W,      32'h104,      32'h0,        32'h0B69EA82, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b111, 32'h3,        32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, W,      32'h104,      32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, W,      32'h400,      32'hA5A5A5A5, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, W,      32'h0,        32'h0,        32'h0,        1'b0});
    vecs[vecs.size()-1].exp_rdata = 32'hA5A5A5A5;

    m_count  = 16'd0;
    m_sticky = 1'b0;
    m_faddr  = 32'd0;

    // Reset with an idle bus.
    rst = 1'b1;
    drive(1'b0, 1'b0, W, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_status("reset");
    chk("reset.rdata", bus.rdata, 32'h0);
    chk("reset.mis", {31'd0, bus.misaligned}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset concurrent with a store: store suppressed, rdata still live.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, W, 32'h0, 32'h0);
    #2;
    chk("rst_store.rdata", bus.rdata, 32'hA5A5A5A5);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, W, 32'h0, 32'h0);
    m_count  = 16'd0;
    m_sticky = 1'b0;
    m_faddr  = 32'd0;
    #2;
    chk("rst_store.after", bus.rdata, 32'hA5A5A5A5);
    check_status("rst_store");

    // Fault latch re-arms after reset.
    apply('{1'b1, 1'b0, W, 32'h6, 32'h0, 32'h0, 1'b1}, 100);
    apply('{1'b0, 1'b1, B, 32'h3, 32'h0000005A, 32'h0, 1'b0}, 101);
    apply('{1'b1, 1'b0, W, 32'h0, 32'h0, 32'h5AA5A5A5, 1'b0}, 102);

    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
